// File: rtl/req_ack_window_checker.sv
// Per-channel req/ack latency window monitor with sticky error flags and a saturating fail counter.
// Verdicts appear one cycle after the deciding edge; passive observer, never stalls the bus it watches.
module req_ack_window_checker #(
  parameter int NCH      = 4,
  parameter int MIN_LAT  = 1,
  parameter int MAX_LAT  = 3,
  parameter int CHK_SPUR = 1,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [NCH-1:0]     ack,
  input  logic               err_clr,
  output logic [NCH-1:0]     pending,
  output logic [NCH-1:0]     pass,
  output logic [NCH-1:0]     fail,
  output logic [2*NCH-1:0]   fail_cause,
  output logic [NCH-1:0]     err_sticky,
  output logic [CNT_W-1:0]   fail_count
);

  localparam int KW = $clog2(MAX_LAT + 1);
  localparam int TW = CNT_W + 7;
  localparam logic [KW-1:0] MIN_K = KW'(MIN_LAT);
  localparam logic [KW-1:0] MAX_K = KW'(MAX_LAT);
  localparam logic [TW-1:0] CAP   = {7'b0, {CNT_W{1'b1}}};

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_EARLY = 2'b01;
  localparam logic [1:0] C_TMO   = 2'b10;
  localparam logic [1:0] C_SPUR  = 2'b11;

  generate
    if (MIN_LAT > MAX_LAT || MAX_LAT < 1 || MAX_LAT > 255 || MIN_LAT < 0) begin : g_bad_lat
      $error("req_ack_window_checker: illegal MIN_LAT/MAX_LAT combination");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
      $error("req_ack_window_checker: NCH must be 1..32");
    end
  endgenerate

  typedef enum logic {IDLE, WAIT} state_t;

  logic [NCH-1:0]   ev_pass;
  logic [NCH-1:0]   ev_fail;
  logic [2*NCH-1:0] ev_cause;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            pass_c, fail_c, resolve_c;
    logic [1:0]      cause_c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        k_q     <= '0;
      end else begin
        state_q <= state_d;
        k_q     <= k_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pass_c    = 1'b0;
      fail_c    = 1'b0;
      cause_c   = C_NONE;
      resolve_c = 1'b0;
      case (state_q)
        IDLE: begin
          if (req[i] && ack[i]) begin
            if (MIN_LAT == 0) begin
              pass_c = 1'b1;
            end else begin
              fail_c  = 1'b1;
              cause_c = C_EARLY;
            end
          end else if (req[i]) begin
            state_d = WAIT;
            k_d     = KW'(1);
          end else if (ack[i] && CHK_SPUR != 0) begin
            fail_c  = 1'b1;
            cause_c = C_SPUR;
          end
        end
        WAIT: begin
          if (ack[i]) begin
            resolve_c = 1'b1;
            if (k_q < MIN_K) begin
              fail_c  = 1'b1;
              cause_c = C_EARLY;
            end else begin
              pass_c = 1'b1;
            end
          end else if (k_q == MAX_K) begin
            resolve_c = 1'b1;
            fail_c    = 1'b1;
            cause_c   = C_TMO;
          end else begin
            k_d = k_q + KW'(1);
          end
          // A req on the resolving edge opens the next transaction immediately.
          if (resolve_c) begin
            state_d = req[i] ? WAIT : IDLE;
            k_d     = req[i] ? KW'(1) : '0;
          end
        end
        default: begin
          state_d = IDLE;
          k_d     = '0;
        end
      endcase
    end

    assign pending[i]         = (state_q == WAIT);
    assign ev_pass[i]         = pass_c;
    assign ev_fail[i]         = fail_c;
    assign ev_cause[2*i +: 2] = cause_c;
  end

  logic [5:0]       fsum;
  logic [TW-1:0]    acc;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    fsum = '0;
    for (int i = 0; i < NCH; i++) begin
      fsum = fsum + 6'(ev_fail[i]);
    end
    acc   = (err_clr ? {TW{1'b0}} : {7'b0, fail_count}) + {{(TW-6){1'b0}}, fsum};
    cnt_d = (acc > CAP) ? {CNT_W{1'b1}} : acc[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass       <= '0;
      fail       <= '0;
      fail_cause <= '0;
      err_sticky <= '0;
      fail_count <= '0;
    end else begin
      pass       <= ev_pass;
      fail       <= ev_fail;
      fail_cause <= ev_cause;
      err_sticky <= (err_clr ? '0 : err_sticky) | ev_fail;
      fail_count <= cnt_d;
    end
  end

endmodule
